// File: rtl/dtc_vote_window.sv
// Temporal majority vote over windows of classifier results: counts votes per class,
// then scans the counters once per window and reports the winning class.
module dtc_vote_window #(
  parameter int WINDOW  = 16,
  parameter int CLASS_W = 3,
  localparam int CNT_W  = $clog2(WINDOW + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CLASS_W-1:0] in_class,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CLASS_W-1:0] out_class,
  output logic [CNT_W-1:0]   out_count,
  output logic [CNT_W-1:0]   out_total
);

  localparam int NCLS = 2 ** CLASS_W;

  typedef enum logic [1:0] {ACCUM, SCAN, REPORT} state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]   cnt [NCLS];
  logic [CNT_W-1:0]   total;
  logic [CNT_W-1:0]   total_inc;
  logic [CLASS_W-1:0] idx;
  logic [CLASS_W-1:0] best_cls;
  logic [CNT_W-1:0]   best_cnt;

  logic               accept;
  logic               close_win;
  logic               last_idx;
  logic               scan_hit;
  logic [CLASS_W-1:0] scan_cls;
  logic [CNT_W-1:0]   scan_cnt;

  assign in_ready  = (state == ACCUM) && !rst;
  assign out_valid = (state == REPORT) && !rst;
  assign accept    = in_valid && in_ready;
  assign total_inc = total + CNT_W'(1);

  // A same-cycle accept counts toward the window that the flush closes.
  assign close_win = (accept && (total_inc == CNT_W'(WINDOW))) ||
                     (flush && ((total != '0) || accept));

  // Strict compare keeps the earlier (lower) class code on ties.
  assign last_idx = (idx == CLASS_W'(NCLS - 1));
  assign scan_hit = cnt[idx] > best_cnt;
  assign scan_cls = scan_hit ? idx : best_cls;
  assign scan_cnt = scan_hit ? cnt[idx] : best_cnt;

  always_ff @(posedge clk) begin
    if (rst) state <= ACCUM;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (close_win) state_nxt = SCAN;
      SCAN:    if (last_idx)  state_nxt = REPORT;
      REPORT:  if (out_ready) state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCLS; i++) cnt[i] <= '0;
      total     <= '0;
      idx       <= '0;
      best_cls  <= '0;
      best_cnt  <= '0;
      out_class <= '0;
      out_count <= '0;
      out_total <= '0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            cnt[in_class] <= cnt[in_class] + CNT_W'(1);
            total         <= total_inc;
          end
        end
        SCAN: begin
          best_cls <= scan_cls;
          best_cnt <= scan_cnt;
          idx      <= idx + CLASS_W'(1);
          if (last_idx) begin
            out_class <= scan_cls;
            out_count <= scan_cnt;
            out_total <= total;
          end
        end
        REPORT: begin
          if (out_ready) begin
            for (int i = 0; i < NCLS; i++) cnt[i] <= '0;
            total    <= '0;
            best_cls <= '0;
            best_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dtc_vote_window.sv
// Randomised self-checking bench for dtc_vote_window against a per-cycle vote-tally model
// that tracks the window contents and the fixed scan delay.
module tb_dtc_vote_window;

  localparam int WINDOW  = 16;
  localparam int CLASS_W = 3;
  localparam int NCLS    = 8;
  localparam int CNT_W   = $clog2(WINDOW + 1);

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [CLASS_W-1:0] in_class;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [CLASS_W-1:0] out_class;
  logic [CNT_W-1:0]   out_count;
  logic [CNT_W-1:0]   out_total;

  int tests;
  int failures;

  // model: phase 0 = collecting, 1 = scanning, 2 = result pending
  int mcnt [NCLS];
  int mtotal;
  int mphase;
  int mscan;
  int exp_cls;
  int exp_cnt;
  int exp_tot;

  dtc_vote_window #(.WINDOW(WINDOW), .CLASS_W(CLASS_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_class  (in_class),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_class (out_class),
    .out_count (out_count),
    .out_total (out_total)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic modelClear();
    for (int i = 0; i < NCLS; i++) mcnt[i] = 0;
    mtotal = 0;
  endtask

  // Winner is the most-voted class, lowest code on ties.
  task automatic modelCloseWindow();
    exp_cls = 0;
    exp_cnt = mcnt[0];
    for (int i = 1; i < NCLS; i++)
      if (mcnt[i] > exp_cnt) begin
        exp_cls = i;
        exp_cnt = mcnt[i];
      end
    exp_tot = mtotal;
    mphase  = 1;
    mscan   = NCLS;
  endtask

  // Called at a negedge; drives one cycle, checks the DUT, advances the model.
  task automatic applyStimulus(input bit v, input int c, input bit f, input bit ordy, input bit r);
    bit acc;
    in_valid  = v;
    in_class  = CLASS_W'(c);
    flush     = f;
    out_ready = ordy;
    rst       = r;
    #1;
    checkOutput("in_ready", int'(in_ready), int'(mphase == 0 && !r));
    checkOutput("out_valid", int'(out_valid), int'(mphase == 2 && !r));
    if (mphase == 2 && !r) begin
      checkOutput("out_class", int'(out_class), exp_cls);
      checkOutput("out_count", int'(out_count), exp_cnt);
      checkOutput("out_total", int'(out_total), exp_tot);
    end
    @(posedge clk);
    if (r) begin
      modelClear();
      mphase = 0;
    end else begin
      case (mphase)
        0: begin
          acc = v;
          if (acc) begin
            mcnt[c]++;
            mtotal++;
          end
          if ((acc && mtotal == WINDOW) || (f && mtotal > 0)) modelCloseWindow();
        end
        1: begin
          mscan--;
          if (mscan == 0) mphase = 2;
        end
        default: begin
          if (ordy) begin
            modelClear();
            mphase = 0;
          end
        end
      endcase
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (mphase != 0 && k < 40) begin
      applyStimulus(0, 0, 0, mphase == 2, 0);
      k++;
    end
    checkOutput("drain_done", mphase, 0);
  endtask

  task automatic waitReport();
    int k;
    k = 0;
    while (mphase != 2 && k < 40) begin
      applyStimulus(0, 0, 0, 0, 0);
      k++;
    end
    checkOutput("reach_report", mphase, 2);
  endtask

  task automatic sendRandom(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1, $urandom_range(NCLS - 1), 0, 0, 0);
  endtask

  initial begin
    int q[$];
    int tmp;
    int j;
    int n;
    tests    = 0;
    failures = 0;
    mphase   = 0;
    mscan    = 0;
    exp_cls  = 0;
    exp_cnt  = 0;
    exp_tot  = 0;
    modelClear();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_class  = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);

    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(1, 2, 1, 1, 1);
    checkOutput("rst_out_class", int'(out_class), 0);
    checkOutput("rst_out_count", int'(out_count), 0);
    checkOutput("rst_out_total", int'(out_total), 0);

    // full window of class 3 and the scan latency
    for (int i = 0; i < 16; i++) applyStimulus(1, 3, 0, 0, 0);
    n = 0;
    while (!out_valid && n < 30) begin
      applyStimulus(0, 0, 0, 0, 0);
      n++;
    end
    checkOutput("latency", n + 1, 9);
    checkOutput("t1_class", exp_cls, 3);
    checkOutput("t1_count", exp_cnt, 16);
    drain();

    // interleaved majority, then a tie
    q.delete();
    for (int i = 0; i < 5; i++) begin q.push_back(2); q.push_back(6); end
    for (int i = 0; i < 6; i++) q.push_back(1);
    for (int i = q.size() - 1; i > 0; i--) begin
      j = $urandom_range(i);
      tmp = q[i]; q[i] = q[j]; q[j] = tmp;
    end
    foreach (q[i]) applyStimulus(1, q[i], 0, 0, 0);
    waitReport();
    checkOutput("t2a_class", int'(out_class), 1);
    checkOutput("t2a_count", int'(out_count), 6);
    drain();
    for (int i = 0; i < 8; i++) applyStimulus(1, 5, 0, 0, 0);
    for (int i = 0; i < 8; i++) applyStimulus(1, 4, 0, 0, 0);
    waitReport();
    checkOutput("t2b_class", int'(out_class), 4);
    checkOutput("t2b_count", int'(out_count), 8);
    drain();

    // consumer stall with upstream still offering samples
    sendRandom(16);
    waitReport();
    for (int i = 0; i < 20; i++) applyStimulus(1, $urandom_range(NCLS - 1), 0, 0, 0);
    applyStimulus(1, 6, 0, 1, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1, $urandom_range(NCLS - 1), 0, 0, 0);
    applyStimulus(1, 2, 1, 0, 0);
    waitReport();
    checkOutput("t3_total", int'(out_total), 4);
    drain();

    // early flush, and flush on an empty window
    applyStimulus(1, 7, 0, 0, 0);
    applyStimulus(1, 7, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0);
    waitReport();
    checkOutput("t4_class", int'(out_class), 7);
    checkOutput("t4_count", int'(out_count), 2);
    checkOutput("t4_total", int'(out_total), 3);
    drain();
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0, 0);
    idle(12);

    // flush coinciding with the closing accept
    sendRandom(15);
    applyStimulus(1, 5, 1, 0, 0);
    waitReport();
    checkOutput("t5a_total", int'(out_total), 16);
    drain();
    idle(12);
    sendRandom(2);
    applyStimulus(1, 1, 1, 0, 0);
    waitReport();
    checkOutput("t5b_total", int'(out_total), 3);
    drain();

    // reset during scan and during a pending report
    sendRandom(5);
    applyStimulus(1, 3, 1, 0, 0);
    idle(3);
    applyStimulus(1, 4, 0, 0, 1);
    applyStimulus(1, 4, 0, 1, 1);
    sendRandom(16);
    drain();
    sendRandom(16);
    waitReport();
    idle(2);
    applyStimulus(1, 2, 0, 0, 1);
    applyStimulus(1, 2, 0, 0, 1);
    sendRandom(3);
    applyStimulus(0, 0, 1, 0, 0);
    waitReport();
    checkOutput("t6_total", int'(out_total), 3);
    drain();

    // random traffic with gaps, stalls, flushes and occasional reset
    for (int i = 0; i < 600; i++)
      applyStimulus($urandom_range(1) == 1, $urandom_range(NCLS - 1),
                    $urandom_range(19) == 0, $urandom_range(1) == 1,
                    $urandom_range(149) == 0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
